// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from an upstream registered-read FIFO and
// sends each as a start bit, DATA_SIZE data bits LSB first, and one stop bit.
module fifo_uart_tx #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_rd_enable,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_SIZE - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;

    assign bit_end        = (baud_q == BAUD_LAST);
    assign fifo_rd_enable = (state_q == FETCH);
    assign busy           = (state_q != IDLE);
    assign tx_done        = (state_q == STOP) && bit_end;
    assign tx             = tx_q;

    // tx_d is set one state early so the registered line changes exactly at the
    // edge that opens each bit period.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                idx_d  = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_data;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, DATA_SIZE=8; a queue
// stands in for the upstream FIFO with registered read data.
module tb_fifo_uart_tx;

    logic       clock;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_enable;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int checks    = 0;
    int failures  = 0;
    int pops      = 0;
    int bad_pops  = 0;
    bit toggle_en = 0;
    bit scramble_en = 0;
    logic [7:0] q[$];

    fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .fifo_rd_enable (fifo_rd_enable),
        .tx             (tx),
        .busy           (busy),
        .tx_done        (tx_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock; the FIFO model answers a pop with data in the following cycle.
    task automatic tick();
        logic rd_prev;
        rd_prev = fifo_rd_enable;
        if (fifo_rd_enable === 1'b1 && fifo_empty && !toggle_en) bad_pops++;
        @(posedge clock);
        #1;
        if (rd_prev === 1'b1) begin
            pops++;
            if (q.size() > 0) fifo_data = q.pop_front();
        end
        if (scramble_en) fifo_data = 8'($urandom);
        if (toggle_en) fifo_empty = ~fifo_empty;
        else           fifo_empty = (q.size() == 0);
    endtask

    task automatic frame(input logic [7:0] exp, input string tag, input bit tog, input bit scr);
        int   n       = 0;
        int   wave_err = 0;
        int   done_n  = 0;
        int   done_at = 0;
        int   rd_n    = 0;
        logic [7:0] got = '0;
        logic exp_bit;
        while (fifo_rd_enable !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_fetch"}, {31'd0, fifo_rd_enable}, 32'd1);
        if (tx !== 1'b1) wave_err++;
        tick();
        if (tx !== 1'b1 || busy !== 1'b1) wave_err++;
        if (fifo_rd_enable !== 1'b0) rd_n++;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (b == 0 && c == 0) begin
                    toggle_en   = tog;
                    scramble_en = scr;
                end
                if (b == 9 && c == 0) toggle_en = 1'b0;
                tick();
                exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
                if (tx !== exp_bit || busy !== 1'b1) wave_err++;
                if (fifo_rd_enable !== 1'b0) rd_n++;
                if (tx_done === 1'b1) begin
                    done_n++;
                    done_at = b * 4 + c + 1;
                end
                if (b >= 1 && b <= 8 && c == 2) got[b-1] = tx;
            end
        end
        scramble_en = 1'b0;
        check({tag, "_wave_err"}, wave_err, 0);
        check({tag, "_byte"}, {24'd0, got}, {24'd0, exp});
        check({tag, "_done_n"}, done_n, 1);
        check({tag, "_done_at"}, done_at, 40);
        check({tag, "_extra_rd"}, rd_n, 0);
    endtask

    initial begin
        int p0;
        int err;
        int n;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;

        repeat (3) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", {31'd0, fifo_rd_enable}, 32'd0);
        check("rst_done", {31'd0, tx_done}, 32'd0);

        reset = 1'b0;
        err = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_enable !== 1'b0 || tx_done !== 1'b0) err++;
        end
        check("idle_quiet", err, 0);
        check("idle_pops", pops, 0);

        // Single byte
        p0 = pops;
        q.push_back(8'hA5);
        fifo_empty = 1'b0;
        frame(8'hA5, "a5", 1'b0, 1'b0);
        tick();
        check("a5_idle_busy", {31'd0, busy}, 32'd0);
        check("a5_pops", pops - p0, 1);

        // Back-to-back with a single IDLE cycle between frames
        p0 = pops;
        q.push_back(8'h01);
        q.push_back(8'hFF);
        fifo_empty = 1'b0;
        frame(8'h01, "b2b_01", 1'b0, 1'b0);
        tick();
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        check("b2b_idle_tx", {31'd0, tx}, 32'd1);
        tick();
        check("b2b_fetch", {31'd0, fifo_rd_enable}, 32'd1);
        frame(8'hFF, "b2b_ff", 1'b0, 1'b0);
        tick();
        check("b2b_pops", pops - p0, 2);

        // Reset in the middle of data bit 3
        p0 = pops;
        q.push_back(8'h34);
        q.push_back(8'h5A);
        fifo_empty = 1'b0;
        n = 0;
        while (fifo_rd_enable !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("abort_fetch", {31'd0, fifo_rd_enable}, 32'd1);
        repeat (1 + 4 + 12 + 1) tick();
        check("abort_mid_busy", {31'd0, busy}, 32'd1);
        check("abort_mid_tx", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        tick();
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, tx_done}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_rd_next", {31'd0, fifo_rd_enable}, 32'd1);
        frame(8'h5A, "abort_next", 1'b0, 1'b0);
        tick();
        check("abort_pops", pops - p0, 2);

        // fifo_empty toggling during the frame
        p0 = pops;
        q.push_back(8'h96);
        fifo_empty = 1'b0;
        frame(8'h96, "tog", 1'b1, 1'b0);
        err = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fifo_rd_enable !== 1'b0) err++;
        end
        check("tog_quiet", err, 0);
        check("tog_pops", pops - p0, 1);

        // fifo_data changing after LOAD
        p0 = pops;
        q.push_back(8'hC3);
        fifo_empty = 1'b0;
        frame(8'hC3, "scr", 1'b0, 1'b1);
        tick();
        check("scr_pops", pops - p0, 1);

        check("pop_while_empty", bad_pops, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
